// File: rtl/usb_dma_pkg.sv
// Shared types and constants for the USB DMA AHB-lite to AXI4 bridge.
// Holds the bridge FSM state enum, AHB encodings and the write-strobe helper.
package usb_dma_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_ID_W       = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WCAP,
    ST_WAXI,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } state_t;

  // Byte lanes of a 32-bit bus touched by an AHB beat.
  function automatic logic [3:0] ahb_strb(
    input logic [2:0] hsize,
    input logic [1:0] addr_lo
  );
    case (hsize)
      3'd0:    ahb_strb = 4'b0001 << addr_lo;
      3'd1:    ahb_strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: ahb_strb = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/axi_bus_if.sv
// 32-bit AXI4 bus bundle between the DMA bridge and the memory crossbar.
// Master drives AW/W/AR and B/R ready; Slave drives the rest.
interface AXI_BUS;
  import usb_dma_pkg::*;

  logic [AXI_ID_W-1:0] aw_id;
  logic [31:0]         aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [2:0]          aw_prot;
  logic                aw_valid;
  logic                aw_ready;

  logic [31:0]         w_data;
  logic [3:0]          w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  logic [AXI_ID_W-1:0] ar_id;
  logic [31:0]         ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [2:0]          ar_prot;
  logic                ar_valid;
  logic                ar_ready;

  logic [31:0]         r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/usb_dma_axi_bridge.sv
// AHB-lite slave (USB DMA side) to single-beat AXI4 master bridge.
// Ports: aclk/areset, AHB h* slave signals, dma_mst AXI_BUS.Master.
module usb_dma_axi_bridge
  import usb_dma_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID      = '0,
  parameter bit                  ERR_ON_WIDE = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp,
  AXI_BUS.Master      dma_mst
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  size_q;
  logic [2:0]  prot_q;
  logic [3:0]  strb_q;
  logic        aw_vld_q;
  logic        w_vld_q;
  logic        ar_vld_q;

  logic addr_ph;
  logic wide;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic unused_ok;

  assign addr_ph = hready & htrans[1];
  assign wide    = ERR_ON_WIDE && (hsize > 3'd2);
  assign aw_hs   = aw_vld_q & dma_mst.aw_ready;
  assign w_hs    = w_vld_q & dma_mst.w_ready;
  assign ar_hs   = ar_vld_q & dma_mst.ar_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      prot_q   <= '0;
      strb_q   <= '0;
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      ar_vld_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (addr_ph) begin
            addr_q <= haddr;
            size_q <= hsize;
            prot_q <= {~hprot[0], 1'b0, hprot[1]};
            strb_q <= ahb_strb(hsize, haddr[1:0]);
            if (wide) begin
              state <= ST_ERR1;
            end else if (hwrite) begin
              state <= ST_WCAP;
            end else begin
              ar_vld_q <= 1'b1;
              state    <= ST_RADDR;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WCAP: begin
          wdata_q  <= hwdata;
          aw_vld_q <= 1'b1;
          w_vld_q  <= 1'b1;
          state    <= ST_WAXI;
        end
        ST_WAXI: begin
          if (aw_hs) aw_vld_q <= 1'b0;
          if (w_hs) w_vld_q <= 1'b0;
          // A channel whose valid is already low handshaked earlier.
          if ((aw_hs || !aw_vld_q) && (w_hs || !w_vld_q))
            state <= ST_WRESP;
        end
        ST_WRESP: begin
          if (dma_mst.b_valid)
            state <= dma_mst.b_resp[1] ? ST_ERR1 : ST_DONE;
        end
        ST_RADDR: begin
          if (ar_hs) begin
            ar_vld_q <= 1'b0;
            state    <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (dma_mst.r_valid) begin
            rdata_q <= dma_mst.r_data;
            state   <= dma_mst.r_resp[1] ? ST_ERR1 : ST_DONE;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hready = (state == ST_IDLE) | (state == ST_DONE)
                | (state == ST_ERR2);
  assign hresp  = ((state == ST_ERR1) | (state == ST_ERR2))
                ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata = rdata_q;

  assign dma_mst.aw_id    = AXI_ID;
  assign dma_mst.aw_addr  = addr_q;
  assign dma_mst.aw_len   = 8'd0;
  assign dma_mst.aw_size  = size_q;
  assign dma_mst.aw_burst = AXI_BURST_INCR;
  assign dma_mst.aw_prot  = prot_q;
  assign dma_mst.aw_valid = aw_vld_q;

  assign dma_mst.w_data   = wdata_q;
  assign dma_mst.w_strb   = strb_q;
  assign dma_mst.w_last   = 1'b1;
  assign dma_mst.w_valid  = w_vld_q;

  assign dma_mst.b_ready  = (state == ST_WRESP);

  assign dma_mst.ar_id    = AXI_ID;
  assign dma_mst.ar_addr  = addr_q;
  assign dma_mst.ar_len   = 8'd0;
  assign dma_mst.ar_size  = size_q;
  assign dma_mst.ar_burst = AXI_BURST_INCR;
  assign dma_mst.ar_prot  = prot_q;
  assign dma_mst.ar_valid = ar_vld_q;

  assign dma_mst.r_ready  = (state == ST_RDATA);

  assign unused_ok = ^{hburst, hprot[3:2], htrans[0],
                       dma_mst.b_resp[0], dma_mst.r_resp[0],
                       dma_mst.r_last};

endmodule
